// File: rtl/mem_arbiter.sv
// Purpose: serialise icache and dcache word requests onto one single-port RAM; dcache 2-word blocks stay atomic.
// Latency: one IDLE arbitration cycle before each grant, then RAM-paced (completion on ramstate==ACCESS).
// Backpressure: iwait/dwait held high until ACCESS; BUSY/FREE/ERROR re-present the request unchanged.
//
// Ports:
//   CLK, nRST                      clock (rising edge), async active-low reset
//   iREN, iaddr -> iwait, iload    icache read port
//   dREN, dWEN, daddr, dstore
//                -> dwait, dload   dcache read/write port (daddr[2] = block word)
//   ramREN, ramWEN, ramaddr,
//   ramstore <- ramload, ramstate  RAM port (ramstate: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR)
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [3:0] STARVE_SAT = 4'd15;

    state_t      state;
    state_t      next_state;
    logic [3:0]  starve;
    logic [3:0]  next_starve;
    logic        dreq;
    logic        access;
    logic        ifirst;

    assign dreq   = dREN | dWEN;
    assign access = (ramstate == RAM_ACCESS);

    // icache overrides dcache only once it has watched enough dcache
    // completions go by while it was waiting.
    assign ifirst = iREN && (starve >= STARVE_LIM);

    // Read data is a straight wire; the wait signals qualify it.
    assign iload = ramload;
    assign dload = ramload;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            starve <= 4'd0;
        end else begin
            state  <= next_state;
            starve <= next_starve;
        end
    end

    always_comb begin
        next_state  = state;
        next_starve = starve;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        iwait       = 1'b1;
        dwait       = 1'b1;

        case (state)
            IDLE: begin
                if (dreq && !ifirst) begin
                    next_state = DGRANT;
                end else if (iREN) begin
                    next_state = IGRANT;
                end
            end

            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iwait   = !access;
                if (!iREN) begin
                    // requester withdrew before the RAM completed
                    next_state = IDLE;
                end else if (access) begin
                    next_starve = 4'd0;
                    next_state  = IDLE;
                end
            end

            DGRANT: begin
                // a write takes precedence over a simultaneous read
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = !access;
                if (!dreq) begin
                    next_state = IDLE;
                end else if (access) begin
                    if (iREN && (starve != STARVE_SAT)) begin
                        next_starve = starve + 4'd1;
                    end
                    // word 0 keeps the grant so word 1 follows with no
                    // icache access slipping in between
                    next_state = daddr[2] ? IDLE : DGRANT;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // advance one clock; inputs are changed and outputs sampled 2ns after the edge
    task automatic tick;
        @(posedge CLK);
        #2;
    endtask

    task automatic test_reset;
        nRST = 1'b0; iREN = 1'b1; iaddr = 32'h40; dREN = 1'b0; dWEN = 1'b0;
        daddr = 32'h0; dstore = 32'h0; ramload = 32'hDEADBEEF; ramstate = ACCESS;
        tick;
        #1;
        checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin errors++; $display("FAIL rst_en got %b%b exp 00", ramREN, ramWEN); end
        checks++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin errors++; $display("FAIL rst_bus got %h/%h exp 0/0", ramaddr, ramstore); end
        checks++; if (iwait !== 1'b1 || dwait !== 1'b1) begin errors++; $display("FAIL rst_wait got %b%b exp 11", iwait, dwait); end
        checks++; if (iload !== 32'hDEADBEEF || dload !== 32'hDEADBEEF) begin errors++; $display("FAIL rst_load got %h/%h exp deadbeef", iload, dload); end
        nRST = 1'b1;
        #1;
        // cycle 0 after release: IDLE arbitration cycle
        checks++; if (iwait !== 1'b1 || ramREN !== 1'b0) begin errors++; $display("FAIL t1_c0 got iwait=%b ramREN=%b exp 1 0", iwait, ramREN); end
        tick;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin errors++; $display("FAIL t1_c1_ram got %b %h exp 1 00000040", ramREN, ramaddr); end
        checks++; if (iwait !== 1'b0 || iload !== 32'hDEADBEEF) begin errors++; $display("FAIL t1_c1_i got %b %h exp 0 deadbeef", iwait, iload); end
        tick;
        iREN = 1'b0;
        #1;
        checks++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin errors++; $display("FAIL t1_idle got %b %b exp 0 1", ramREN, iwait); end
        tick;
    endtask

    task automatic test_writeback;
        dWEN = 1'b1; daddr = 32'h108; dstore = 32'hA0A0A0A0; ramstate = BUSY;
        iREN = 1'b1; iaddr = 32'h80;
        #1;
        checks++; if (ramWEN !== 1'b0 || dwait !== 1'b1) begin errors++; $display("FAIL wb_idle got %b %b exp 0 1", ramWEN, dwait); end
        tick;
        for (int c = 0; c < 2; c++) begin
            checks++; if (ramWEN !== 1'b1 || ramaddr !== 32'h108 || ramstore !== 32'hA0A0A0A0) begin errors++; $display("FAIL wb_w0_busy%0d got %b %h %h exp 1 108 a0a0a0a0", c, ramWEN, ramaddr, ramstore); end
            checks++; if (dwait !== 1'b1 || iwait !== 1'b1) begin errors++; $display("FAIL wb_w0_wait%0d got %b %b exp 1 1", c, dwait, iwait); end
            tick;
        end
        ramstate = ACCESS;
        #1;
        checks++; if (dwait !== 1'b0 || ramWEN !== 1'b1) begin errors++; $display("FAIL wb_w0_done got %b %b exp 0 1", dwait, ramWEN); end
        tick;
        // word 1; dREN also raised to confirm the write still wins
        daddr = 32'h10C; dstore = 32'hB1B1B1B1; dREN = 1'b1; ramstate = BUSY;
        #1;
        checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h10C) begin errors++; $display("FAIL wb_w1_lock got %b %b %h exp 1 0 10c", ramWEN, ramREN, ramaddr); end
        checks++; if (iwait !== 1'b1 || dwait !== 1'b1) begin errors++; $display("FAIL wb_w1_wait got %b %b exp 1 1", iwait, dwait); end
        tick;
        tick;
        ramstate = ACCESS;
        #1;
        checks++; if (dwait !== 1'b0 || ramstore !== 32'hB1B1B1B1) begin errors++; $display("FAIL wb_w1_done got %b %h exp 0 b1b1b1b1", dwait, ramstore); end
        tick;
        dWEN = 1'b0; dREN = 1'b0;
        #1;
        checks++; if (iwait !== 1'b1 || ramREN !== 1'b0) begin errors++; $display("FAIL wb_idle2 got %b %b exp 1 0", iwait, ramREN); end
        tick;
        checks++; if (iwait !== 1'b0 || ramREN !== 1'b1 || ramaddr !== 32'h80) begin errors++; $display("FAIL wb_igrant got %b %b %h exp 0 1 80", iwait, ramREN, ramaddr); end
        tick;
        iREN = 1'b0;
        tick;
    endtask

    task automatic test_simultaneous;
        iREN = 1'b1; iaddr = 32'h90; dREN = 1'b1; daddr = 32'h304; ramstate = BUSY;
        tick;
        checks++; if (ramaddr !== 32'h304 || ramREN !== 1'b1 || iwait !== 1'b1 || dwait !== 1'b1) begin errors++; $display("FAIL sim_dfirst got %h %b %b %b exp 304 1 1 1", ramaddr, ramREN, iwait, dwait); end
        tick;
        ramstate = ACCESS;
        ramload = 32'h12345678;
        #1;
        checks++; if (dwait !== 1'b0 || iwait !== 1'b1 || dload !== 32'h12345678) begin errors++; $display("FAIL sim_ddone got %b %b %h exp 0 1 12345678", dwait, iwait, dload); end
        tick;
        dREN = 1'b0;
        #1;
        checks++; if (iwait !== 1'b1) begin errors++; $display("FAIL sim_idle got %b exp 1", iwait); end
        tick;
        checks++; if (iwait !== 1'b0 || ramaddr !== 32'h90) begin errors++; $display("FAIL sim_igrant got %b %h exp 0 90", iwait, ramaddr); end
        tick;
        iREN = 1'b0;
        tick;
    endtask

    task automatic test_starvation;
        iREN = 1'b1; iaddr = 32'h500; dREN = 1'b1; daddr = 32'h400; ramstate = ACCESS;
        for (int b = 0; b < 2; b++) begin
            #1;
            checks++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin errors++; $display("FAIL st_idle%0d got %b %b exp 0 1", b, ramREN, iwait); end
            tick;
            checks++; if (ramaddr !== 32'h400 || dwait !== 1'b0 || iwait !== 1'b1) begin errors++; $display("FAIL st_w0_%0d got %h %b %b exp 400 0 1", b, ramaddr, dwait, iwait); end
            tick;
            daddr = 32'h404;
            #1;
            checks++; if (ramaddr !== 32'h404 || dwait !== 1'b0) begin errors++; $display("FAIL st_w1_%0d got %h %b exp 404 0", b, ramaddr, dwait); end
            tick;
            daddr = 32'h400;
        end
        // four dcache completions seen: icache now wins the IDLE cycle
        tick;
        checks++; if (ramaddr !== 32'h500 || iwait !== 1'b0 || dwait !== 1'b1) begin errors++; $display("FAIL st_igrant got %h %b %b exp 500 0 1", ramaddr, iwait, dwait); end
        tick;
        tick;
        // fairness count cleared: dcache wins again
        checks++; if (ramaddr !== 32'h400 || dwait !== 1'b0 || iwait !== 1'b1) begin errors++; $display("FAIL st_cleared got %h %b %b exp 400 0 1", ramaddr, dwait, iwait); end
        tick;
        dREN = 1'b0; iREN = 1'b0;
        #1;
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL st_drop got %b exp 0", ramREN); end
        tick;
    endtask

    task automatic test_error;
        dREN = 1'b1; daddr = 32'h200; ramstate = ERROR;
        tick;
        for (int c = 0; c < 3; c++) begin
            checks++; if (dwait !== 1'b1 || ramaddr !== 32'h200 || ramREN !== 1'b1) begin errors++; $display("FAIL err_c%0d got %b %h %b exp 1 200 1", c, dwait, ramaddr, ramREN); end
            tick;
        end
        ramstate = ACCESS;
        #1;
        checks++; if (dwait !== 1'b0 || ramaddr !== 32'h200) begin errors++; $display("FAIL err_done got %b %h exp 0 200", dwait, ramaddr); end
        tick;
        // 0x200 is word 0, so the lock holds until dREN is withdrawn
        dREN = 1'b0; ramstate = BUSY;
        #1;
        checks++; if (ramREN !== 1'b0 || dwait !== 1'b1) begin errors++; $display("FAIL err_wd got %b %b exp 0 1", ramREN, dwait); end
        tick;
    endtask

    task automatic test_withdraw_reset;
        dREN = 1'b1; daddr = 32'h304; ramstate = BUSY;
        tick;
        checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL wd_grant got %b exp 1", ramREN); end
        tick;
        dREN = 1'b0;
        #1;
        checks++; if (ramREN !== 1'b0 || dwait !== 1'b1) begin errors++; $display("FAIL wd_drop got %b %b exp 0 1", ramREN, dwait); end
        tick;
        dREN = 1'b1;
        #1;
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL wd_idle got %b exp 0", ramREN); end
        tick;
        dWEN = 1'b1; dstore = 32'hCAFEF00D;
        #1;
        checks++; if (ramWEN !== 1'b1 || ramstore !== 32'hCAFEF00D) begin errors++; $display("FAIL rs_pre got %b %h exp 1 cafef00d", ramWEN, ramstore); end
        nRST = 1'b0;
        #1;
        checks++; if (ramWEN !== 1'b0 || ramREN !== 1'b0 || ramaddr !== 32'h0 || ramstore !== 32'h0) begin errors++; $display("FAIL rs_async got %b %b %h %h exp 0 0 0 0", ramWEN, ramREN, ramaddr, ramstore); end
        checks++; if (dwait !== 1'b1 || iwait !== 1'b1) begin errors++; $display("FAIL rs_wait got %b %b exp 1 1", dwait, iwait); end
        tick;
        nRST = 1'b1;
        #1;
        checks++; if (ramWEN !== 1'b0) begin errors++; $display("FAIL rs_idle got %b exp 0", ramWEN); end
        tick;
        checks++; if (ramWEN !== 1'b1 || ramaddr !== 32'h304) begin errors++; $display("FAIL rs_regrant got %b %h exp 1 304", ramWEN, ramaddr); end
        dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
        tick;
    endtask

    initial begin
        test_reset;
        test_writeback;
        test_simultaneous;
        test_starvation;
        test_error;
        test_withdraw_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
